// File: rtl/mcu_spi_tx_fifo.sv
// SPI-slave transmit path: words queued in a small FIFO are serialised onto
// mcu_sdo. mcu_sck and mcu_cs_n are oversampled on fpga_sck, not used as clocks.
module mcu_spi_tx_fifo #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 4,
   parameter bit          CPOL      = 1'b0,
   parameter bit          CPHA      = 1'b0,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_SDO  = 1'b0
) (
   input  logic                   fpga_sck,
   input  logic                   reset,
   input  logic                   mcu_sck,
   input  logic                   mcu_cs_n,
   input  logic                   load,
   input  logic [WIDTH-1:0]       data_load,
   output logic                   mcu_sdo,
   output logic                   ready,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy,
   output logic                   word_done,
   output logic                   underrun,
   output logic                   overflow,
   output logic                   aborted
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned BW   = $clog2(WIDTH + 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
   logic [2:0]       sck_sync;
   logic [2:0]       cs_sync;

   logic             sck_rise_c, sck_fall_c, lead_c, trail_c;
   logic             launch_c, sample_c, cs_fall_c, cs_rise_c;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CNTW-1:0]  count_d;
   logic             push_c, pop_c;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             need_load_q, need_load_d;
   logic             load_word_c;
   logic             word_done_d, underrun_d, aborted_d;
   logic             sdo_bit_c;

   // Two-flop synchronisers plus one edge-detect stage, reset to idle levels
   always_ff @(posedge fpga_sck) begin
      if (reset) begin
         sck_sync <= {3{CPOL}};
         cs_sync  <= 3'b111;
      end else begin
         sck_sync <= {sck_sync[1:0], mcu_sck};
         cs_sync  <= {cs_sync[1:0], mcu_cs_n};
      end
   end

   // Map raw SCK edges onto launch/sample; SCK edges are ignored while CS is high
   always_comb begin
      sck_rise_c = sck_sync[1] & ~sck_sync[2];
      sck_fall_c = ~sck_sync[1] & sck_sync[2];
      cs_fall_c  = ~cs_sync[1] & cs_sync[2];
      cs_rise_c  = cs_sync[1] & ~cs_sync[2];
      lead_c     = CPOL ? sck_fall_c : sck_rise_c;
      trail_c    = CPOL ? sck_rise_c : sck_fall_c;
      launch_c   = (CPHA ? lead_c : trail_c) & ~cs_sync[1];
      sample_c   = (CPHA ? trail_c : lead_c) & ~cs_sync[1];
   end

   // Push is gated by the registered ready only, so a same-cycle pop never frees a slot
   assign push_c  = load & ready;
   assign count_d = fifo_count + CNTW'(push_c) - CNTW'(pop_c);

   // FIFO pointers, occupancy, ready and overflow pulse
   always_ff @(posedge fpga_sck) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         ready      <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= count_d;
         ready      <= (count_d != CNTW'(DEPTH));
         overflow   <= load & ~ready;
      end
   end

   // FIFO storage (contents need no reset; pointers define validity)
   always_ff @(posedge fpga_sck) begin
      if (push_c) mem[wr_ptr] <= data_load;
   end

   assign sdo_bit_c = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

   // Next-state, shifter and pulse logic
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      need_load_d = need_load_q;
      load_word_c = 1'b0;
      pop_c       = 1'b0;
      word_done_d = 1'b0;
      underrun_d  = 1'b0;
      aborted_d   = 1'b0;
      case (state_q)
         IDLE: begin
            bit_cnt_d   = '0;
            need_load_d = 1'b0;
            if (cs_fall_c) begin
               state_d = ACTIVE;
               if (CPHA) need_load_d = 1'b1;
               else      load_word_c = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise_c) begin
               state_d     = IDLE;
               // a loaded word that has not reached WIDTH samples is cut short
               aborted_d   = ~need_load_q & (bit_cnt_q != BW'(WIDTH));
               bit_cnt_d   = '0;
               need_load_d = 1'b0;
            end else begin
               if (sample_c && (bit_cnt_q != BW'(WIDTH))) begin
                  bit_cnt_d   = bit_cnt_q + BW'(1);
                  word_done_d = (bit_cnt_q == BW'(WIDTH - 1));
               end
               if (launch_c) begin
                  if (need_load_q || (bit_cnt_q == BW'(WIDTH))) load_word_c = 1'b1;
                  else if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
                  else                sr_d = {1'b0, sr_q[WIDTH-1:1]};
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_word_c) begin
         pop_c       = (fifo_count != '0);
         sr_d        = (fifo_count != '0) ? mem[rd_ptr] : '0;
         underrun_d  = (fifo_count == '0);
         bit_cnt_d   = '0;
         need_load_d = 1'b0;
      end
   end

   // State, shifter and registered outputs
   always_ff @(posedge fpga_sck) begin
      if (reset) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         need_load_q <= 1'b0;
         mcu_sdo     <= IDLE_SDO;
         busy        <= 1'b0;
         word_done   <= 1'b0;
         underrun    <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         need_load_q <= need_load_d;
         mcu_sdo     <= (state_q == ACTIVE) ? sdo_bit_c : IDLE_SDO;
         busy        <= (state_d == ACTIVE);
         word_done   <= word_done_d;
         underrun    <= underrun_d;
         aborted     <= aborted_d;
      end
   end

endmodule

// File: tb/tb_mcu_spi_tx_fifo.sv
// Bench for mcu_spi_tx_fifo: a mode-0 MSB-first instance and a mode-3
// LSB-first instance, driven by a bit-banged SPI master with a scoreboard.
module tb_mcu_spi_tx_fifo;
   localparam int unsigned W = 16;
   localparam int HALF = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   sck, cs_n, load;
   logic [W-1:0] din [2];
   logic [1:0]   sdo, rdy, busy, wd, ur, ov, ab;
   logic [2:0]   cnt [2];

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_w [2][$];
   logic [W-1:0] rx_w  [2][$];
   int           exp_ev [2][$];   // 1 underrun, 2 overflow, 3 aborted

   always #5 clk = ~clk;

   mcu_spi_tx_fifo #(.WIDTH(16), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0),
                     .MSB_FIRST(1'b1), .IDLE_SDO(1'b0)) u_m0 (
      .fpga_sck(clk), .reset(reset), .mcu_sck(sck[0]), .mcu_cs_n(cs_n[0]),
      .load(load[0]), .data_load(din[0]), .mcu_sdo(sdo[0]), .ready(rdy[0]),
      .fifo_count(cnt[0]), .busy(busy[0]), .word_done(wd[0]), .underrun(ur[0]),
      .overflow(ov[0]), .aborted(ab[0]));

   mcu_spi_tx_fifo #(.WIDTH(16), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1),
                     .MSB_FIRST(1'b0), .IDLE_SDO(1'b0)) u_m3 (
      .fpga_sck(clk), .reset(reset), .mcu_sck(sck[1]), .mcu_cs_n(cs_n[1]),
      .load(load[1]), .data_load(din[1]), .mcu_sdo(sdo[1]), .ready(rdy[1]),
      .fifo_count(cnt[1]), .busy(busy[1]), .word_done(wd[1]), .underrun(ur[1]),
      .overflow(ov[1]), .aborted(ab[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int d, input logic [W-1:0] v, input bit expect_tx);
      load[d] = 1'b1;
      din[d]  = v;
      cyc(1);
      load[d] = 1'b0;
      if (expect_tx) exp_w[d].push_back(v);
   endtask

   // One CS frame of nbits; bits are captured just before each sample edge
   task automatic xfer(input int d, input int nbits);
      logic [W-1:0] sh = '0;
      int nb = 0;
      cs_n[d] = 1'b0;
      cyc(HALF);
      for (int i = 0; i < nbits; i++) begin
         if (d == 1) begin
            sck[d] = 1'b0;
            cyc(HALF);
         end
         if (d == 0) sh = {sh[W-2:0], sdo[d]};
         else        sh = {sdo[d], sh[W-1:1]};
         nb++;
         if (nb == W) begin
            rx_w[d].push_back(sh);
            nb = 0;
         end
         sck[d] = 1'b1;
         cyc(HALF);
         if (d == 0 && i != nbits - 1) begin
            sck[d] = 1'b0;
            cyc(HALF);
         end
      end
      cs_n[d] = 1'b1;
      cyc(HALF);
      sck[d] = (d == 1);
      cyc(HALF);
   endtask

   task automatic ev_chk(input int d, input int code);
      if (exp_ev[d].size() == 0) begin
         total++;
         bad++;
         $display("FAIL event%0d: unexpected pulse code %0d", d, code);
      end else begin
         chk($sformatf("event%0d", d), 32'(code), 32'(exp_ev[d].pop_front()));
      end
   endtask

   // Scoreboard monitor: pops expectations whenever the DUT reports something
   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (wd[d]) begin
               if (exp_w[d].size() == 0 || rx_w[d].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL word%0d: word_done with rx=%0d exp=%0d queued",
                           d, rx_w[d].size(), exp_w[d].size());
               end else begin
                  chk($sformatf("word%0d", d), 32'(rx_w[d].pop_front()),
                      32'(exp_w[d].pop_front()));
               end
            end
            if (ur[d]) ev_chk(d, 1);
            if (ov[d]) ev_chk(d, 2);
            if (ab[d]) ev_chk(d, 3);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      sck    = 2'b10;
      cs_n   = 2'b11;
      load   = 2'b00;
      din[0] = '0;
      din[1] = '0;
      fork
         monitor();
      join_none
      cyc(3);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_sdo%0d", d),    32'(sdo[d]),  32'd0);
         chk($sformatf("rst_ready%0d", d),  32'(rdy[d]),  32'd1);
         chk($sformatf("rst_count%0d", d),  32'(cnt[d]),  32'd0);
         chk($sformatf("rst_busy%0d", d),   32'(busy[d]), 32'd0);
         chk($sformatf("rst_pulses%0d", d), 32'({wd[d], ur[d], ov[d], ab[d]}), 32'd0);
      end
      reset = 1'b0;
      cyc(4);

      // mode 0, one word
      push(0, 16'hA5C3, 1'b1);
      chk("m0_count_before", 32'(cnt[0]), 32'd1);
      xfer(0, 16);
      chk("m0_count_after", 32'(cnt[0]), 32'd0);
      chk("m0_busy_after", 32'(busy[0]), 32'd0);

      // mode 3, LSB first, two words back-to-back
      push(1, 16'h1234, 1'b1);
      push(1, 16'hBEEF, 1'b1);
      chk("m3_count_before", 32'(cnt[1]), 32'd2);
      xfer(1, 32);
      chk("m3_count_after", 32'(cnt[1]), 32'd0);

      // underrun, then a normal word
      exp_w[0].push_back(16'h0000);
      exp_ev[0].push_back(1);
      xfer(0, 16);
      push(0, 16'h00FF, 1'b1);
      xfer(0, 16);

      // overflow: fifth push dropped
      push(0, 16'h1111, 1'b1);
      push(0, 16'h2222, 1'b1);
      push(0, 16'h3333, 1'b1);
      chk("ovf_ready_3", 32'(rdy[0]), 32'd1);
      push(0, 16'h4444, 1'b1);
      chk("ovf_ready_4", 32'(rdy[0]), 32'd0);
      chk("ovf_count_4", 32'(cnt[0]), 32'd4);
      exp_ev[0].push_back(2);
      push(0, 16'h5555, 1'b0);
      cyc(1);
      chk("ovf_count_5", 32'(cnt[0]), 32'd4);
      xfer(0, 64);
      chk("ovf_count_end", 32'(cnt[0]), 32'd0);
      chk("ovf_ready_end", 32'(rdy[0]), 32'd1);

      // abort after 7 bits; remainder is discarded
      push(0, 16'hFFFF, 1'b0);
      push(0, 16'h0F0F, 1'b1);
      exp_ev[0].push_back(3);
      xfer(0, 7);
      chk("abort_sdo_idle", 32'(sdo[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_count", 32'(cnt[0]), 32'd1);
      xfer(0, 16);
      chk("abort_next_count", 32'(cnt[0]), 32'd0);

      // reset in the middle of a transfer
      push(0, 16'hFC00, 1'b0);
      push(0, 16'h7FFE, 1'b0);
      cs_n[0] = 1'b0;
      cyc(HALF);
      repeat (5) begin
         sck[0] = 1'b1;
         cyc(HALF);
         sck[0] = 1'b0;
         cyc(HALF);
      end
      chk("rstmid_busy_before", 32'(busy[0]), 32'd1);
      chk("rstmid_sdo_before", 32'(sdo[0]), 32'd1);
      reset = 1'b1;
      cyc(1);
      chk("rstmid_count", 32'(cnt[0]), 32'd0);
      chk("rstmid_busy", 32'(busy[0]), 32'd0);
      chk("rstmid_ready", 32'(rdy[0]), 32'd1);
      chk("rstmid_sdo", 32'(sdo[0]), 32'd0);
      chk("rstmid_pulses", 32'({wd[0], ur[0], ov[0], ab[0]}), 32'd0);
      cs_n[0] = 1'b1;
      cyc(4);
      reset = 1'b0;
      cyc(HALF);
      chk("rstmid_busy_after", 32'(busy[0]), 32'd0);

      // every expected word and event must have been consumed
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("left_words%0d", d),  32'(exp_w[d].size()),  32'd0);
         chk($sformatf("left_rx%0d", d),     32'(rx_w[d].size()),   32'd0);
         chk($sformatf("left_events%0d", d), 32'(exp_ev[d].size()), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mcu_spi_tx_fifo.md
# mcu_spi_tx_fifo

Parametrised SPI-slave transmit path from the FPGA to the MCU. Words written in the `fpga_sck` domain are queued in a small FIFO, then serialised onto `mcu_sdo` under control of the MCU's `mcu_sck` and `mcu_cs_n`, which are oversampled rather than used as clocks. It supports back-to-back multi-word transfers, all four SPI modes and either bit order, with underrun, overflow and abort reporting. It replaces the single-register, dual-clock transmit shifter on the MCU link.

## Interface
- `WIDTH`, 16: bits per word, ≥2.
- `DEPTH`, 4: FIFO entries, a power of 2 and ≥2.
- `CPOL`, 0: idle level of `mcu_sck`.
- `CPHA`, 0: 0 means launch on the trailing edge (first bit valid before the first edge); 1 means launch on the leading edge.
- `MSB_FIRST`, 1: 1 shifts out the MSB first; 0 shifts out the LSB first.
- `IDLE_SDO`, 0: level driven on `mcu_sdo` while not selected.
- `fpga_sck`  in  1: the only clock; all logic runs on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `mcu_sck`  in  1: SPI clock from the MCU (asynchronous).
- `mcu_cs_n`  in  1: chip select from the MCU, active-low (asynchronous).
- `load`  in  1: push strobe for `data_load`.
- `data_load`  in  WIDTH: word to queue.
- `mcu_sdo`  out  1: serial data to the MCU.
- `ready`  out  1: FIFO not full.
- `fifo_count`  out  $clog2(DEPTH)+1: occupancy.
- `busy`  out  1: FSM in ACTIVE.
- `word_done`  out  1: 1-cycle pulse after the WIDTH-th sample edge of a word.
- `underrun`  out  1: 1-cycle pulse when a word load finds the FIFO empty.
- `overflow`  out  1: 1-cycle pulse when `load` is asserted while full.
- `aborted`  out  1: 1-cycle pulse when CS deasserts mid-word.

## Operation
- **Synchronisers.** `mcu_sck` and `mcu_cs_n` each pass through a 2-FF synchroniser, then a registered edge detect.
- **Edge definitions.**
  - Leading edge: rising when CPOL=0, falling when CPOL=1.
  - Launch edge: trailing edge when CPHA=0, leading edge when CPHA=1.
  - Sample edge: the opposite edge to launch.
- **FIFO.**
  - `load` with `ready`=1 pushes the word.
  - `load` when full drops the word and pulses `overflow`.
  - A push and a pop in the same cycle are both honoured; `fifo_count` is unchanged.
  - `ready` depends only on the registered count. A pop in the same cycle does not allow a push into a full FIFO.
- **State IDLE.**
  - `mcu_sdo`=IDLE_SDO and `bit_cnt`=0.
  - On the synchronised CS falling edge the FSM moves to ACTIVE.
  - If CPHA=0, it also loads a word immediately.
  - If CPHA=1, it sets `need_load` instead.
- **Word load.**
  - The FIFO head is popped into the shift register.
  - If the FIFO is empty, all-zeros is loaded and `underrun` pulses.
  - `bit_cnt` is cleared.
- **State ACTIVE.**
  - `mcu_sdo` is `sr[WIDTH-1]` when MSB_FIRST=1, otherwise `sr[0]`.
  - Sample edge: `bit_cnt`++. When it reaches WIDTH, `word_done` pulses.
  - Launch edge with `need_load`=1 or `bit_cnt`==WIDTH: do a word load and clear `need_load`.
  - Any other launch edge: shift one bit toward the output end, zero-filling.
  - Multi-word transfers are continuous; there is no gap between words.
- **CS rising edge (ACTIVE → IDLE).**
  - If 0 < `bit_cnt` < WIDTH, or a CPHA=0 word is loaded with `bit_cnt`=0, `aborted` pulses.
  - The remainder of the word is discarded and not returned to the FIFO.
  - A CS rise with `bit_cnt`==WIDTH, or with `need_load` still set, is a clean end with no pulse.
- **Edge ordering.** SCK edges seen while CS is deasserted, or in the same cycle as the CS-rise detect, are ignored.

## Timing
- Reset values:
  - `mcu_sdo`=IDLE_SDO, `ready`=1, `fifo_count`=0, `busy`=0.
  - All pulse outputs 0, FIFO empty, FSM in IDLE, synchroniser stages reset to the idle levels (CPOL and 1).
- Reset asserted mid-transfer clears everything on the next edge. The FIFO contents are lost and no `aborted` pulse is produced.
- Input edge to action: 3 `fpga_sck` cycles (2 sync + 1 detect). `mcu_sdo` changes on the cycle after the action.
- CS fall to first bit valid (CPHA=0): 4 cycles.
- Requirements on the MCU side:
  - Each `mcu_sck` half-period must be at least 6 `fpga_sck` cycles.
  - CS-to-first-SCK-edge setup must be at least 6 cycles.
- Push to `fifo_count` update: 1 cycle.
- `word_done` fires 3 cycles after the WIDTH-th sample edge on the pins.

## Test plan
- **Mode 0, one word.** WIDTH=16, CPOL=0, CPHA=0, MSB_FIRST=1. Push 0xA5C3, then run 16 SCK cycles → sampled bits equal 0xA5C3 MSB first; one `word_done`; `fifo_count` 1→0; no `underrun`.
- **Mode 3, LSB first, back-to-back.** CPOL=1, CPHA=1, MSB_FIRST=0. Push 0x1234 and 0xBEEF, then run 32 SCK cycles under a single CS → LSB-first 0x1234 followed by 0xBEEF; two `word_done` pulses; no gap bits.
- **Underrun.** Empty FIFO, select and clock 16 bits → all-zero word and one `underrun` pulse. A second select after pushing 0x00FF sends 0x00FF.
- **Overflow.** DEPTH=4, push 5 words → `ready`=0 after the 4th; `overflow` pulses on the 5th; `fifo_count`=4; only the first 4 words are transmitted, in order.
- **Abort.** Raise CS after 7 bits of 0xFFFF → `aborted` pulses; `mcu_sdo` returns to IDLE_SDO; the next select transmits the next queued word, not the remaining 9 bits.
- **Reset mid-transfer.** Assert `reset` after 5 bits with 2 words queued → next cycle shows `fifo_count`=0, `busy`=0, `ready`=1, `mcu_sdo`=IDLE_SDO, and no pulses.
